// File: rtl/ram_writer.sv
// ram_writer: small 2^ADDR_W x DATA_W memory loaded from a valid/ready stream,
// with a combinational read port compatible with the lookup ROM it replaces.
module ram_writer #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_en;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // A word transfers only while loading and upstream offers one
  assign wr_en = busy_q & wr_valid;

  // Next-state, pointer/count and decoded-output computation
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            wr_ptr_d    = start_addr;
            remaining_d = len;
            state_d     = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (wr_en) begin
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  // Control registers; outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Memory array: cleared by reset, one word written per accepted transfer
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else if (wr_en && (wr_ptr_q == ADDR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  assign wr_ready = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = mem_q[rd_addr];

endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed and randomized loads checked against a memory model.
module tb_ram_writer;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] dq [$];

  ram_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("%s_mem%0d", tag, i), 32'(rd_data), 32'(model[i]));
    end
  endtask

  // vmode: 0 = valid always high, 1 = random valid, 2 = valid from vpat bits
  task automatic load(input logic [AW-1:0] a, input int n, input int vmode,
                      input logic [15:0] vpat, input bit stray, input string tag);
    int rem, cyc, idx;
    logic [AW-1:0] ptr;
    logic          v;
    logic [DW-1:0] d;
    start      = 1'b1;
    start_addr = a;
    len        = (AW+1)'(n);
    wr_valid   = 1'b0;
    tick();
    start      = 1'b0;
    start_addr = AW'($urandom);
    len        = (AW+1)'($urandom);
    if (n == 0) begin
      chk({tag, "_zero_done"}, 32'(done), 32'd1);
      chk({tag, "_zero_ready"}, 32'(wr_ready), 32'd0);
      tick();
      chk({tag, "_zero_done_end"}, 32'(done), 32'd0);
      chk({tag, "_zero_ready_end"}, 32'(wr_ready), 32'd0);
      return;
    end
    rem = n;
    ptr = a;
    cyc = 0;
    idx = 0;
    while (rem > 0 && cyc < 100) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 99) < 60);
        default: v = vpat[idx[3:0]];
      endcase
      d = (v && dq.size() > 0) ? dq.pop_front() : DW'($urandom);
      wr_valid = v;
      wr_data  = d;
      if (stray) begin
        start      = 1'($urandom);
        start_addr = AW'($urandom);
        len        = (AW+1)'($urandom);
      end
      rd_addr = ptr;
      #1;
      chk({tag, "_rd_old"}, 32'(rd_data), 32'(model[ptr]));
      tick();
      start = 1'b0;
      if (v) begin
        model[ptr] = d;
        chk({tag, "_rd_new"}, 32'(rd_data), 32'(d));
        ptr = ptr + AW'(1);
        rem--;
      end
      cyc++;
      idx++;
    end
    wr_valid = 1'b0;
    if (rem > 0) chk({tag, "_timeout"}, 32'(rem), 32'd0);
    if (vmode == 0) chk({tag, "_latency"}, 32'(cyc), 32'(n));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_ready"}, 32'(wr_ready), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk_mem(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_mem("rst");

    dq = '{8'h01, 8'h02, 8'h04, 8'h08};
    load(2'd0, 4, 0, 16'h0, 1'b0, "basic");

    dq = '{8'hAA, 8'hBB};
    load(2'd3, 2, 0, 16'h0, 1'b0, "wrap");

    dq = '{8'h11, 8'h22, 8'h33};
    load(2'd1, 3, 2, 16'b101001, 1'b0, "bp");

    load(2'd2, 0, 0, 16'h0, 1'b0, "zero");
    chk_mem("zero");

    dq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    load(2'd2, 4, 0, 16'h0, 1'b1, "stray");

    dq = '{8'h5A};
    load(2'd1, 1, 0, 16'h0, 1'b0, "rdw");

    for (int k = 0; k < 30; k++) begin
      dq.delete();
      load(AW'($urandom), $urandom_range(0, DEPTH), 1, 16'h0, 1'($urandom), "rand");
    end

    // Reset in the middle of a four-word load
    start = 1'b1; start_addr = 2'd0; len = 3'd4;
    tick();
    start = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hE1;
    tick();
    wr_data = 8'hE2;
    tick();
    wr_data = 8'hE3;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_valid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    chk_mem("mid_rst");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_nodone", 32'(done), 32'd0);
      chk("mid_rst_idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
